// File: rtl/parity_gen_stage.sv
// Inserts a parity bit into each source word, with optional deliberate corruption,
// and buffers it through a 2-entry skid buffer that drives the FIFO push side.
module parity_gen_stage #(
  parameter int   DATA_WIDTH = 17,
  parameter logic PARITY     = 1'b1,
  parameter logic P_BIT      = 1'b1,
  parameter int   CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  output logic                  grant_out,
  input  logic [DATA_WIDTH-2:0] data_in,
  input  logic                  inject_err,
  output logic                  valid_out,
  input  logic                  grant_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic [CNT_WIDTH-1:0]  inj_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] skid_q;
  logic                  pend_q;
  logic                  valid_q;
  logic                  grant_q;
  logic [CNT_WIDTH-1:0]  word_cnt_q;
  logic [CNT_WIDTH-1:0]  inj_cnt_q;

  logic                  acc;
  logic                  xfer;
  logic                  corrupt;
  logic                  par;
  logic                  par_ins;
  logic [DATA_WIDTH-1:0] word_d;

  always_comb begin
    acc     = valid_in & grant_q;
    xfer    = valid_q & grant_in;
    corrupt = inject_err | pend_q;
    par     = PARITY ? (^data_in) : (~^data_in);
    par_ins = par ^ corrupt;
    word_d  = P_BIT ? {data_in, par_ins} : {par_ins, data_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      pend_q     <= 1'b0;
      valid_q    <= 1'b0;
      grant_q    <= 1'b1;
      word_cnt_q <= '0;
      inj_cnt_q  <= '0;
    end else begin
      // An injection request survives until exactly one word absorbs it.
      if (acc) begin
        pend_q <= 1'b0;
      end else if (inject_err) begin
        pend_q <= 1'b1;
      end
      if (acc && corrupt) begin
        inj_cnt_q <= inj_cnt_q + CNT_WIDTH'(1);
      end
      if (xfer) begin
        word_cnt_q <= word_cnt_q + CNT_WIDTH'(1);
      end

      case (state_q)
        EMPTY: begin
          if (acc) begin
            main_q  <= word_d;
            state_q <= ONE;
            valid_q <= 1'b1;
            grant_q <= 1'b1;
          end
        end
        ONE: begin
          if (acc && !xfer) begin
            skid_q  <= word_d;
            state_q <= TWO;
            grant_q <= 1'b0;
          end else if (xfer && !acc) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
          end else if (acc && xfer) begin
            main_q <= word_d;
          end
        end
        TWO: begin
          if (xfer) begin
            main_q  <= skid_q;
            state_q <= ONE;
            grant_q <= 1'b1;
          end
        end
        default: begin
          state_q <= EMPTY;
          valid_q <= 1'b0;
          grant_q <= 1'b1;
        end
      endcase
    end
  end

  assign valid_out = valid_q;
  assign grant_out = grant_q;
  assign data_out  = main_q;
  assign word_cnt  = word_cnt_q;
  assign inj_cnt   = inj_cnt_q;

endmodule

// File: doc/parity_gen_stage.md
Name: parity_gen_stage

Overview:
- Upstream producer stage for the parity-checked FIFO.
- Takes raw payload words from the source, computes and inserts the parity bit, and buffers through a 2-entry skid buffer.
- Drives the FIFO push side using the valid/grant handshake at full throughput.
- Includes a test hook that deliberately corrupts parity, plus transfer and injection counters for the checker bench.

Parameters:
- DATA_WIDTH, 17: width of the protected word including the parity bit; payload is DATA_WIDTH-1 bits.
- PARITY, 1'b1: 1'b1 = even parity, 1'b0 = odd parity.
- P_BIT, 1'b1: parity bit position; 1'b1 = LSB, 1'b0 = MSB.
- CNT_WIDTH, 16: width of the word and injection counters.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- valid_in  input  1  source presents a payload word.
- grant_out  output  1  stage can accept a word this cycle.
- data_in  input  DATA_WIDTH-1  payload.
- inject_err  input  1  request to corrupt the parity of one word.
- valid_out  output  1  word available to the FIFO.
- grant_in  input  1  FIFO accepts the word this cycle.
- data_out  output  DATA_WIDTH  payload with parity inserted.
- word_cnt  output  CNT_WIDTH  count of words delivered downstream.
- inj_cnt  output  CNT_WIDTH  count of corrupted words accepted.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous, active-high.
- Reset values:
  - valid_out=0, grant_out=1, data_out=0.
  - word_cnt=0, inj_cnt=0.
  - pending-inject flag=0; buffer state EMPTY.
- Reset asserted mid-operation discards buffered words immediately (asynchronous); it does not wait for a clock edge.
- Handshakes:
  - Input transfer: valid_in & grant_out.
  - Output transfer: valid_out & grant_in.
  - valid_out must not depend combinationally on grant_in.
  - grant_out is registered and does not depend on valid_in.
- Parity bit p:
  - Even (PARITY=1): p = XOR-reduce(payload).
  - Odd (PARITY=0): p = XNOR-reduce(payload).
  - Result: total ones in the word are even or odd respectively.
- Word assembly, computed at input acceptance:
  - P_BIT=1: {payload, p}.
  - P_BIT=0: {p, payload}.
- Injection:
  - A word is corrupted if inject_err=1 in its acceptance cycle, or the pending flag is set.
  - A corrupted word has p inverted before storage.
  - inject_err=1 with no acceptance that cycle sets the pending flag.
  - Any acceptance clears the flag.
  - Multiple inject_err pulses before one acceptance corrupt only that one word.
  - inj_cnt increments on each corrupted acceptance.
- Buffer: main register drives data_out; skid register holds overflow.
- States:
  - EMPTY (valid_out=0, grant_out=1).
  - ONE (valid_out=1, grant_out=1).
  - TWO (valid_out=1, grant_out=0).
- Transitions:
  - EMPTY: accept -> ONE (word into main).
  - ONE: accept & no output -> TWO (word into skid).
  - ONE: output & no accept -> EMPTY.
  - ONE: accept & output same cycle -> ONE (new word into main).
  - TWO: output -> ONE (skid moves to main; grant_out=1 next cycle).
  - TWO: no output -> hold.
- Latency: a word accepted at edge N is on data_out with valid_out=1 after edge N; sustained throughput is 1 word/cycle.
- Ordering: strict FIFO order; data_out is stable while valid_out=1 and grant_in=0.
- word_cnt increments on each output transfer.
- Both counters wrap modulo 2^CNT_WIDTH with no saturation.

Test Plan:
- Reset, then a single word: data_in=16'h0003, PARITY=1, P_BIT=1, grant_in=1 -> next cycle data_out=17'h00006, valid_out=1; word_cnt=1 after the transfer.
- Parity/position sweep with data_in=16'h0001:
  - PARITY=1, P_BIT=0 -> data_out=17'h10001.
  - PARITY=0, P_BIT=1 -> data_out=17'h00002.
- Backpressure: grant_in=0, push A and B -> grant_out=0 after B, data_out=A held stable. Then grant_in=1 -> A, then B, delivered in order; grant_out returns to 1 one cycle after A leaves.
- Streaming: 100 consecutive words with grant_in=1 -> one word per cycle, no bubbles, word_cnt=100.
- Injection, pending path: inject_err pulsed twice while valid_in=0, then push 16'h0003 -> data_out=17'h00007, inj_cnt=1; the following word has correct parity.
- Reset mid-stream: assert rst asynchronously while in TWO -> valid_out=0, grant_out=1, counters=0 immediately, before the next clock edge.
